// File: rtl/alu_instr_issuer.sv
// alu_instr_issuer: debounced go press issues one {sel,rs,rt} instruction over valid/ready and collects the result with a timeout
module alu_instr_issuer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw_rs,
    input  logic [3:0]  sw_rt,
    input  logic [2:0]  sw_sel,
    input  logic        go_btn,
    output logic [10:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [3:0]  res,
    input  logic        res_valid,
    output logic [3:0]  result,
    output logic        result_valid,
    output logic        timeout_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state;
    logic s1, s, deb, deb_d, start;
    logic [7:0] cnt, timer;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s1 <= 1'b0;
            s <= 1'b0;
            deb <= 1'b0;
            deb_d <= 1'b0;
            start <= 1'b0;
            cnt <= '0;
            timer <= '0;
            instr <= '0;
            instr_valid <= 1'b0;
            result <= '0;
            result_valid <= 1'b0;
            timeout_err <= 1'b0;
            busy <= 1'b0;
        end else begin
            s1 <= go_btn;
            s <= s1;
            // deb flips on the edge where the mismatch count would reach DEBOUNCE_CYCLES
            if (s == deb) cnt <= '0;
            else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
                deb <= s;
                cnt <= '0;
            end else cnt <= cnt + 8'd1;
            deb_d <= deb;
            start <= deb & ~deb_d;
            case (state)
                IDLE: if (start) begin
                    instr <= {sw_sel, sw_rs, sw_rt};
                    instr_valid <= 1'b1;
                    result_valid <= 1'b0;
                    timeout_err <= 1'b0;
                    busy <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: if (instr_ready) begin
                    instr_valid <= 1'b0;
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: if (res_valid) begin
                    result <= res;
                    result_valid <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end else if (timer == 8'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end else timer <= timer + {7'd0, timer != 8'hFF};
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_instr_issuer.sv
// tb_alu_instr_issuer: randomized scenario bench for alu_instr_issuer with a spec-level expectation model
module tb_alu_instr_issuer;
    localparam int D = 4;
    localparam int T = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] sw_rs = '0, sw_rt = '0, res = '0;
    logic [2:0] sw_sel = '0;
    logic go_btn = 1'b0, instr_ready = 1'b0, res_valid = 1'b0;
    logic [10:0] instr;
    logic instr_valid, result_valid, timeout_err, busy;
    logic [3:0] result;
    logic [3:0] exp_result = '0;
    int total = 0, bad = 0;

    alu_instr_issuer #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .sw_rs(sw_rs), .sw_rt(sw_rt), .sw_sel(sw_sel), .go_btn(go_btn),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .res(res),
        .res_valid(res_valid), .result(result), .result_valid(result_valid),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Press from a settled idle state, expect issue 4+D edges later, hold ready low for rdly cycles, then transfer.
    task automatic press_issue(input logic [2:0] sel, input logic [3:0] rs, input logic [3:0] rt, input int rdly);
        logic [10:0] exp_i;
        int n;
        exp_i = {sel, rs, rt};
        sw_sel = sel; sw_rs = rs; sw_rt = rt;
        repeat (10) @(negedge clk);
        go_btn = 1'b1;
        instr_ready = (rdly == 0);
        n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 4 + D) begin bad++; $display("FAIL issue_latency got=%0d exp=%0d", n, 4 + D); end
        total++;
        if (instr !== exp_i) begin bad++; $display("FAIL instr got=%h exp=%h", instr, exp_i); end
        go_btn = 1'b0;
        sw_sel = 3'($urandom); sw_rs = 4'($urandom); sw_rt = 4'($urandom);
        repeat (rdly) begin
            @(negedge clk);
            sw_rs = 4'($urandom);
            total++;
            if (instr_valid !== 1'b1 || instr !== exp_i) begin
                bad++; $display("FAIL hold got=%b/%h exp=1/%h", instr_valid, instr, exp_i);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        total++;
        if (instr_valid !== 1'b0 || busy !== 1'b1 || instr !== exp_i) begin
            bad++; $display("FAIL transfer got=%b/%b/%h exp=0/1/%h", instr_valid, busy, instr, exp_i);
        end
        instr_ready = 1'b0;
    endtask

    // Return res on the d-th WAIT edge; d beyond T means no response, so expect a timeout at edge T.
    task automatic respond(input int d, input logic [3:0] v);
        int k, kd;
        kd = (d <= T) ? d : T;
        for (k = 1; k <= 40; k++) begin
            res = v;
            res_valid = (k == d);
            @(negedge clk);
            if (!busy) break;
        end
        res_valid = 1'b0;
        if (d <= T) exp_result = v;
        total++;
        if (k != kd) begin bad++; $display("FAIL wait_len got=%0d exp=%0d", k, kd); end
        total++;
        if (result !== exp_result || result_valid !== (d <= T) || timeout_err !== (d > T)) begin
            bad++; $display("FAIL outcome got=%h/%b/%b exp=%h/%b/%b", result, result_valid, timeout_err,
                            exp_result, d <= T, d > T);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({instr, instr_valid, result, result_valid, timeout_err, busy} !== '0) begin
            bad++; $display("FAIL reset got=%h/%b/%h/%b/%b/%b exp=0", instr, instr_valid, result, result_valid, timeout_err, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        press_issue(3'b001, 4'h5, 4'h3, 0);
        total++;
        if (instr !== 11'h153) begin bad++; $display("FAIL basic_instr got=%h exp=153", instr); end
        respond(2, 4'h8);
        total++;
        if (busy !== 1'b0 || result !== 4'h8) begin bad++; $display("FAIL basic_done got=%b/%h exp=0/8", busy, result); end
    endtask

    task automatic test_backpressure;
        press_issue(3'b001, 4'h5, 4'h3, 10);
        total++;
        if (instr !== 11'h153) begin bad++; $display("FAIL bp_instr got=%h exp=153", instr); end
        respond($urandom_range(1, T), 4'($urandom));
    endtask

    task automatic test_timeout;
        press_issue(3'($urandom), 4'($urandom), 4'($urandom), 0);
        respond(T + 5, 4'h0);
        res = ~exp_result;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        total++;
        if (result !== exp_result || result_valid !== 1'b0 || timeout_err !== 1'b1) begin
            bad++; $display("FAIL late_res got=%h/%b/%b exp=%h/0/1", result, result_valid, timeout_err, exp_result);
        end
    endtask

    task automatic test_bounce;
        int issues;
        logic prev;
        for (int i = 0; i < 30; i++) begin
            go_btn = (i % 4) < 2;
            @(negedge clk);
            total++;
            if (instr_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bounce got=%b/%b exp=0/0", instr_valid, busy); end
        end
        go_btn = 1'b0;
        repeat (10) @(negedge clk);
        go_btn = 1'b1;
        instr_ready = 1'b1;
        issues = 0;
        prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid && !prev) issues++;
            prev = instr_valid;
        end
        go_btn = 1'b0;
        instr_ready = 1'b0;
        total++;
        if (issues != 1 || busy !== 1'b0 || timeout_err !== 1'b1) begin
            bad++; $display("FAIL clean_press got=%0d/%b/%b exp=1/0/1", issues, busy, timeout_err);
        end
    endtask

    task automatic test_busy_coincident;
        int k;
        press_issue(3'($urandom), 4'($urandom), 4'($urandom), 0);
        for (k = 1; k <= 40; k++) begin
            if (k == 8) go_btn = 1'b1;
            res = 4'hF;
            res_valid = (k == T);
            @(negedge clk);
            if (!busy) break;
        end
        res_valid = 1'b0;
        exp_result = 4'hF;
        total++;
        if (k != T || result !== 4'hF || result_valid !== 1'b1 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL coincident got=%0d/%h/%b/%b exp=%0d/f/1/0", k, result, result_valid, timeout_err, T);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            total++;
            if (instr_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL no_reissue got=%b/%b exp=0/0", instr_valid, busy); end
        end
        go_btn = 1'b0;
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            press_issue(3'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 4));
            respond($urandom_range(1, T + 4), 4'($urandom));
        end
    endtask

    task automatic test_reset_mid;
        repeat (10) @(negedge clk);
        go_btn = 1'b1;
        instr_ready = 1'b0;
        repeat (4 + D + 2) @(negedge clk);
        go_btn = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (instr_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_issue got=%b/%b exp=0/0", instr_valid, busy); end
        @(negedge clk);
        rst = 1'b0;
        exp_result = '0;
        press_issue(3'($urandom), 4'($urandom), 4'($urandom), 0);
        respond(3, 4'hA);
        press_issue(3'($urandom), 4'($urandom), 4'($urandom), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({instr_valid, busy, result, result_valid, timeout_err} !== '0) begin
            bad++; $display("FAIL rst_wait got=%b/%b/%h/%b/%b exp=0", instr_valid, busy, result, result_valid, timeout_err);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_result = '0;
        press_issue(3'b101, 4'hC, 4'h7, 1);
        respond(5, 4'h6);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_timeout;
        test_bounce;
        test_busy_coincident;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
